// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// FSM encoding, default frame marker and the count range check.
package imem_loader_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CNT_HI = 3'd1;
   localparam logic [2:0] S_CNT_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_CHK    = 3'd5;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // A frame may fill the whole memory but never more.
   function automatic logic count_too_big(input logic [15:0] cnt,
                                          input int unsigned aw);
      logic [16:0] lim;
      lim = 17'd1 << aw;
      return {1'b0, cnt} > lim;
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs data bytes MSB first into a 32-bit word
// and keeps the running XOR of every byte taken.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_en,
   input  logic        clr,
   output logic [31:0] word,
   output logic        word_full,
   output logic [7:0]  chk
);

   logic [31:0] word_q, word_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  chk_q, chk_d;

   always_comb begin
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      chk_d      = chk_q;
      if (clr) begin
         word_d     = '0;
         byte_idx_d = '0;
         chk_d      = '0;
      end else if (byte_en) begin
         word_d     = {word_q[23:0], byte_in};
         byte_idx_d = byte_idx_q + 2'd1;
         chk_d      = chk_q ^ byte_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q     <= '0;
         byte_idx_q <= '0;
         chk_q      <= '0;
      end else begin
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         chk_q      <= chk_d;
      end
   end

   // byte_idx wraps to 0 on the 4th byte, ready for the next word
   assign word_full = byte_en & ~clr & (byte_idx_q == 2'd3);
   assign word      = word_q;
   assign chk       = chk_q;

endmodule

// File: rtl/imem_loader.sv
// Frame parser that writes a checksummed program image into
// instruction RAM and holds the CPU until the load verifies.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int          DATA_W    = 32,
   parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);

   logic [2:0]        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [15:0]       widx_q, widx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic        xfer;
   logic        asm_en;
   logic        asm_clr;
   logic [31:0] asm_word;
   logic        asm_full;
   logic [7:0]  asm_chk;
   logic [15:0] cnt_new;
   logic        is_sync;
   logic        last_word;

   assign rx_ready  = (state_q != S_WRITE);
   assign xfer      = rx_valid & rx_ready;
   assign is_sync   = (rx_data == SYNC_BYTE);
   assign asm_en    = xfer & (state_q == S_DATA);
   assign asm_clr   = xfer & (state_q == S_IDLE) & is_sync;
   assign cnt_new   = {cnt_q[15:8], rx_data};
   assign last_word = (widx_q == cnt_q - 16'd1);

   word_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .byte_in   (rx_data),
      .byte_en   (asm_en),
      .clr       (asm_clr),
      .word      (asm_word),
      .word_full (asm_full),
      .chk       (asm_chk)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (xfer && is_sync) begin
               hold_d  = 1'b1;
               err_d   = 1'b0;
               state_d = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (xfer) begin
               cnt_d   = {rx_data, 8'h00};
               state_d = S_CNT_LO;
            end
         end
         S_CNT_LO: begin
            if (xfer) begin
               cnt_d = cnt_new;
               if (cnt_new == 16'd0) begin
                  state_d = S_CHK;
               end else if (count_too_big(cnt_new, ADDR_W)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  widx_d  = '0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (asm_full) state_d = S_WRITE;
         end
         S_WRITE: begin
            // latch what is on the bus so it holds once im_we drops
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = asm_word;
            if (last_word) begin
               state_d = S_CHK;
            end else begin
               widx_d  = widx_q + 16'd1;
               state_d = S_DATA;
            end
         end
         S_CHK: begin
            if (xfer) begin
               if (rx_data == asm_chk) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign im_we     = (state_q == S_WRITE);
   assign im_addr   = im_we ? widx_q[ADDR_W-1:0] : addr_q;
   assign im_wdata  = im_we ? asm_word : wdata_q;
   assign cpu_hold  = hold_q;
   assign busy      = (state_q != S_IDLE);
   assign load_done = done_q;
   assign load_err  = err_q;

endmodule
